lock_mode_controller: RTL and testbench

Sequencing FSM for the combination lock. It owns the 3-bit `state` code that drives the display multiplexer and the entry/storage blocks. It walks the user through secret-data entry, new-password entry, new-password confirmation display, password entry and unlocked data display. It also enforces a wrong-attempt limit with a timed lockout, and emits the load/clear strobes the storage and digit-entry blocks need on each mode change.

---
 rtl/lock_mode_controller.sv | 157 +++++++++++++++
 tb/tb_lock_mode_controller.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/lock_mode_controller.sv
// lock_mode_controller
//   Sequencing FSM for the combination lock: secret-data entry, new-password
//   entry, new-password confirmation display, password entry and unlocked
//   data display, with a wrong-attempt limit and timed lockout.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   button_enter      debounced level, acts on rising edge
//   button_lock       debounced level, acts on rising edge
//   pass_match        entered password equals stored password
//   state             mode code 0..4 for display mux and entry blocks
//   load_data         one-cycle strobe: latch entered digits as secret data
//   load_pass         one-cycle strobe: latch entered digits as password
//   clear_entry       one-cycle strobe: clear the entry block
//   unlocked          high while state == SHOW_DATA
//   lockout           high while a lockout is running
//   attempts          consecutive wrong passwords
module lock_mode_controller #(
   parameter int unsigned MAX_ATTEMPTS   = 3,
   parameter int unsigned LOCKOUT_CYCLES = 1000,
   parameter int unsigned SHOW_CYCLES    = 100
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  button_enter,
   input  logic                                  button_lock,
   input  logic                                  pass_match,
   output logic [2:0]                            state,
   output logic                                  load_data,
   output logic                                  load_pass,
   output logic                                  clear_entry,
   output logic                                  unlocked,
   output logic                                  lockout,
   output logic [$clog2(MAX_ATTEMPTS+1)-1:0]     attempts
);

   localparam int unsigned AW = $clog2(MAX_ATTEMPTS + 1);
   localparam int unsigned SW = $clog2(SHOW_CYCLES);
   localparam int unsigned LW = $clog2(LOCKOUT_CYCLES);

   localparam logic [AW-1:0] MAX_A     = AW'(MAX_ATTEMPTS);
   localparam logic [SW-1:0] SHOW_LOAD = SW'(SHOW_CYCLES - 1);
   localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      INSERT_DATA    = 3'd0,
      INSERT_NEWPASS = 3'd1,
      SHOW_NEWPASS   = 3'd2,
      INSERT_PASS    = 3'd3,
      SHOW_DATA      = 3'd4
   } state_t;

   state_t          st;
   logic            enter_q;
   logic            lock_q;
   logic [SW-1:0]   show_timer;
   logic [LW-1:0]   lock_timer;
   logic            enter_p;
   logic            lock_p;
   logic [AW-1:0]   attempts_inc;

   assign enter_p      = button_enter & ~enter_q;
   assign lock_p       = button_lock & ~lock_q;
   assign attempts_inc = attempts + 1'b1;
   assign state        = st;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st          <= INSERT_DATA;
         enter_q     <= 1'b0;
         lock_q      <= 1'b0;
         show_timer  <= '0;
         lock_timer  <= '0;
         load_data   <= 1'b0;
         load_pass   <= 1'b0;
         clear_entry <= 1'b0;
         unlocked    <= 1'b0;
         lockout     <= 1'b0;
         attempts    <= '0;
      end else begin
         enter_q     <= button_enter;
         lock_q      <= button_lock;
         load_data   <= 1'b0;
         load_pass   <= 1'b0;
         clear_entry <= 1'b0;

         case (st)
            INSERT_DATA: begin
               if (enter_p) begin
                  load_data   <= 1'b1;
                  clear_entry <= 1'b1;
                  st          <= INSERT_NEWPASS;
               end
            end

            // No clear here: the new password stays visible during the show.
            INSERT_NEWPASS: begin
               if (enter_p) begin
                  load_pass  <= 1'b1;
                  show_timer <= SHOW_LOAD;
                  st         <= SHOW_NEWPASS;
               end
            end

            SHOW_NEWPASS: begin
               if (show_timer == '0) begin
                  clear_entry <= 1'b1;
                  st          <= INSERT_PASS;
               end else begin
                  show_timer <= show_timer - 1'b1;
               end
            end

            // Lockout can only start and expire here, so its timer lives here.
            INSERT_PASS: begin
               if (lockout) begin
                  if (lock_timer == '0) begin
                     lockout <= 1'b0;
                  end else begin
                     lock_timer <= lock_timer - 1'b1;
                  end
               end else if (enter_p) begin
                  clear_entry <= 1'b1;
                  if (pass_match) begin
                     attempts <= '0;
                     unlocked <= 1'b1;
                     st       <= SHOW_DATA;
                  end else if (attempts_inc == MAX_A) begin
                     lockout    <= 1'b1;
                     lock_timer <= LOCK_LOAD;
                     attempts   <= '0;
                  end else begin
                     attempts <= attempts_inc;
                  end
               end
            end

            SHOW_DATA: begin
               if (lock_p) begin
                  clear_entry <= 1'b1;
                  unlocked    <= 1'b0;
                  st          <= INSERT_PASS;
               end else if (enter_p) begin
                  clear_entry <= 1'b1;
                  unlocked    <= 1'b0;
                  st          <= INSERT_DATA;
               end
            end

            default: begin
               unlocked <= 1'b0;
               st       <= INSERT_DATA;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lock_mode_controller.sv
// tb_lock_mode_controller
//   Self-checking bench for lock_mode_controller. A behavioural model tracks
//   the mode, attempt count and absolute deadlines (cycle numbers) for the
//   confirmation display and the lockout; every cycle the DUT outputs are
//   compared against it. Directed scenarios are followed by random stimulus.
module tb_lock_mode_controller;

   localparam int unsigned MAXA = 3;
   localparam int unsigned LOCK = 1000;
   localparam int unsigned SHOW = 100;
   localparam int unsigned AW   = $clog2(MAXA + 1);

   logic          clk = 1'b0;
   logic          rst_n;
   logic          button_enter;
   logic          button_lock;
   logic          pass_match;
   logic [2:0]    state;
   logic          load_data;
   logic          load_pass;
   logic          clear_entry;
   logic          unlocked;
   logic          lockout;
   logic [AW-1:0] attempts;

   int unsigned checks = 0;
   int unsigned errors = 0;

   lock_mode_controller #(
      .MAX_ATTEMPTS   (MAXA),
      .LOCKOUT_CYCLES (LOCK),
      .SHOW_CYCLES    (SHOW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .button_enter (button_enter),
      .button_lock  (button_lock),
      .pass_match   (pass_match),
      .state        (state),
      .load_data    (load_data),
      .load_pass    (load_pass),
      .clear_entry  (clear_entry),
      .unlocked     (unlocked),
      .lockout      (lockout),
      .attempts     (attempts)
   );

   always #5 clk = ~clk;

   // Reference model: mode number, deadlines as absolute cycle numbers.
   int  cyc = 0;
   int  m_mode;
   int  m_att;
   int  show_end;
   int  lock_end;
   bit  m_locked;
   bit  m_ld, m_lp, m_ce;
   bit  prev_e, prev_l;

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s cycle %0d got %0d expected %0d", tag, cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_att = 0; m_locked = 0;
      m_ld = 0; m_lp = 0; m_ce = 0;
      prev_e = 0; prev_l = 0;
      show_end = 0; lock_end = 0;
   endtask

   task automatic model_step(input bit e, input bit l, input bit pm);
      bit ep, lp;
      ep = e && !prev_e;
      lp = l && !prev_l;
      prev_e = e;
      prev_l = l;
      m_ld = 0; m_lp = 0; m_ce = 0;
      case (m_mode)
         0: if (ep) begin m_mode = 1; m_ld = 1; m_ce = 1; end
         1: if (ep) begin m_mode = 2; m_lp = 1; show_end = cyc + SHOW; end
         2: if (cyc == show_end) begin m_mode = 3; m_ce = 1; end
         3: begin
            if (m_locked) begin
               if (cyc == lock_end) m_locked = 0;
            end else if (ep) begin
               m_ce = 1;
               if (pm) begin
                  m_mode = 4;
                  m_att  = 0;
               end else begin
                  m_att++;
                  if (m_att == MAXA) begin
                     m_locked = 1;
                     lock_end = cyc + LOCK;
                     m_att    = 0;
                  end
               end
            end
         end
         4: begin
            if (lp) begin m_mode = 3; m_ce = 1; end
            else if (ep) begin m_mode = 0; m_ce = 1; end
         end
         default: m_mode = 0;
      endcase
   endtask

   task automatic compare_all();
      check("state", state, m_mode);
      check("strobes", {load_data, load_pass, clear_entry}, {m_ld, m_lp, m_ce});
      check("unlocked", unlocked, (m_mode == 4));
      check("lockout", lockout, m_locked);
      check("attempts", attempts, m_att);
   endtask

   // Called at a negedge: drive inputs, advance one clock, compare.
   task automatic tick(input bit e, input bit l, input bit pm);
      button_enter = e;
      button_lock  = l;
      pass_match   = pm;
      @(posedge clk);
      if (!rst_n) model_reset();
      else        model_step(e, l, pm);
      cyc++;
      @(negedge clk);
      compare_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(0, 0, 0);
   endtask

   task automatic press(input bit pm);
      tick(1, 0, pm);
      tick(0, 0, pm);
   endtask

   // Asynchronous reset between edges; outputs must clear before any edge.
   task automatic async_reset(input string tag);
      #2;
      rst_n = 1'b0;
      #1;
      check({tag, "_state"}, state, 0);
      check({tag, "_outs"}, {load_data, load_pass, clear_entry, unlocked, lockout}, 0);
      check({tag, "_att"}, attempts, 0);
      model_reset();
      @(negedge clk);
      button_enter = 0; button_lock = 0; pass_match = 0;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      button_enter = 0; button_lock = 0; pass_match = 0;
      model_reset();
      @(negedge clk);
      idle(2);
      rst_n = 1'b1;
      idle(2);

      // Program data and password, wait out the confirmation display.
      press(0);
      press(0);
      idle(SHOW + 2);

      // Correct password, then lock.
      press(1);
      idle(2);
      tick(0, 1, 0);
      tick(0, 0, 0);

      // Three wrong passwords, enter during lockout, wait it out.
      press(0);
      press(0);
      press(0);
      idle(10);
      press(1);
      idle(LOCK);

      // Unlock, reprogram, hold enter for 50 cycles in mode 0.
      press(1);
      press(0);
      for (int i = 0; i < 50; i++) tick(1, 0, 0);
      idle(1);

      // Into show display, then reset mid-show.
      press(0);
      idle(20);
      async_reset("rst_show");
      idle(1);

      // Back to SHOW_DATA, simultaneous enter and lock.
      press(0);
      press(0);
      idle(SHOW + 1);
      press(1);
      tick(1, 1, 0);
      tick(0, 0, 0);

      // Lockout, then reset mid-lockout.
      press(0);
      press(0);
      press(0);
      idle(30);
      async_reset("rst_lock");
      idle(1);

      // Random stimulus.
      for (int i = 0; i < 15000; i++) begin
         tick($urandom_range(0, 99) < 35,
              $urandom_range(0, 99) < 20,
              $urandom_range(0, 1) == 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
